// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared types, state encodings and exception causes for the fetch stage.
package fetch_stage_pkg;
    localparam logic [1:0] ST_RESET = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_IDLE  = 2'd3;

    localparam logic [3:0] except_instr_misaligned   = 4'd0;
    localparam logic [3:0] except_instr_access_fault = 4'd1;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exception;
        logic [3:0]  ecause;
        logic [31:0] etval;
    } fetch_out_type;

    typedef struct packed {
        logic [1:0]    state;
        logic [31:0]   pc;
        logic [31:0]   addr;
        logic          halt;
        logic          skid_valid;
        fetch_out_type skid;
        fetch_out_type f;
    } fetch_reg_type;

    // Word holding pc, or the following word when the low half already sits in the buffer.
    function automatic logic [31:0] word_addr(input logic [31:0] pc, input logic skip);
        return {pc[31:2], 2'b00} + (skip ? 32'd4 : 32'd0);
    endfunction
endpackage

// File: rtl/fetch_align.sv
// fetch_align: combinational halfword assembly and 16/32-bit classification of a fetched word.
// With COMPRESSED_EN undefined every word is a 32-bit instruction at pc+4.
module fetch_align
    import fetch_stage_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] rdata,
`ifdef COMPRESSED_EN
    input  logic        hb_hit,
    input  logic [15:0] hb_data,
    output logic        issue,
    output logic        hb_set,
    output logic        buf16,
`endif
    output logic [31:0] instr,
    output logic [31:0] next_pc
);
`ifdef COMPRESSED_EN
    logic [15:0] lo;
    logic        is16;
    always_comb begin
        lo      = hb_hit ? hb_data : (pc[1] ? rdata[31:16] : rdata[15:0]);
        is16    = lo[1:0] != 2'b11;
        // An upper-half 32-bit start with nothing buffered only primes the buffer.
        issue   = is16 | hb_hit | ~pc[1];
        hb_set  = pc[1] ^ is16;
        buf16   = hb_hit & is16;
        instr   = is16 ? {16'b0, lo} : (hb_hit ? {rdata[15:0], hb_data} : rdata);
        next_pc = !issue ? pc : pc + (is16 ? 32'd2 : 32'd4);
    end
`else
    assign instr   = rdata;
    assign next_pc = pc + 32'd4;
`endif
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: single-outstanding instruction fetch with skid register and redirect drain.
// COMPRESSED_EN enables 16-bit instructions via a halfword buffer; otherwise misaligned redirects fault.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h80000000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_valid,
    output logic        imem_instr,
    output logic [3:0]  imem_wstrb,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        f_valid,
    output logic [31:0] f_pc,
    output logic [31:0] f_instr,
    output logic        f_exception,
    output logic [3:0]  f_ecause,
    output logic [31:0] f_etval
);
    fetch_reg_type r;
    fetch_out_type pkt;
    logic [31:0]   instr, next_pc, nxt_addr, idle_addr;
    logic          issue, buf16, nxt_idle;
    logic          rsp, fault, take_buf, apply, outstanding;

`ifdef COMPRESSED_EN
    logic        hb_valid, hb_hit, hb_set;
    logic [15:0] hb_data;
    logic [31:0] hb_addr;
    assign hb_hit    = hb_valid & r.pc[1] & (hb_addr == r.pc);
    assign nxt_addr  = word_addr(next_pc, hb_set);
    assign nxt_idle  = hb_set & (imem_rdata[17:16] != 2'b11);
    assign idle_addr = word_addr(r.pc, hb_hit);
`else
    assign issue     = 1'b1;
    assign buf16     = 1'b0;
    assign nxt_idle  = 1'b0;
    assign nxt_addr  = next_pc;
    assign idle_addr = r.pc;
`endif

    fetch_align u_align (
        .pc      (r.pc),
        .rdata   (imem_rdata),
`ifdef COMPRESSED_EN
        .hb_hit  (hb_hit),
        .hb_data (hb_data),
        .issue   (issue),
        .hb_set  (hb_set),
        .buf16   (buf16),
`endif
        .instr   (instr),
        .next_pc (next_pc)
    );

    assign rsp         = r.state == ST_REQ && imem_ready;
    assign fault       = rsp && imem_err;
    assign take_buf    = r.state == ST_IDLE && !r.halt && !r.skid_valid && buf16 && !stall;
    assign apply       = (rsp && !imem_err) || take_buf;
    assign outstanding = (r.state == ST_REQ || r.state == ST_DRAIN) && !imem_ready;

    always_comb begin
        pkt           = '0;
        pkt.valid     = 1'b1;
        pkt.pc        = r.pc;
        pkt.instr     = fault ? 32'd0 : instr;
        pkt.exception = fault;
        pkt.ecause    = fault ? except_instr_access_fault : 4'd0;
        pkt.etval     = fault ? r.pc : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r       <= '0;
            r.state <= ST_RESET;
            r.pc    <= RESET_PC;
            r.addr  <= RESET_PC;
            r.f.pc  <= RESET_PC;
`ifdef COMPRESSED_EN
            hb_valid <= 1'b0;
`endif
        end else if (redirect) begin
            r.f.valid     <= 1'b0;
            r.f.exception <= 1'b0;
            r.skid_valid  <= 1'b0;
            r.halt        <= 1'b0;
            r.pc          <= redirect_pc & ~32'd1;
            r.state       <= outstanding ? ST_DRAIN : ST_REQ;
            if (!outstanding) r.addr <= {redirect_pc[31:2], 2'b00};
`ifdef COMPRESSED_EN
            hb_valid <= 1'b0;
`else
            // The fault waits in the skid so decode sees it after the flush bubble.
            if (redirect_pc[1]) begin
                r.halt       <= 1'b1;
                r.skid_valid <= 1'b1;
                r.skid       <= '{valid: 1'b1, pc: redirect_pc, instr: 32'd0, exception: 1'b1,
                                  ecause: except_instr_misaligned, etval: redirect_pc};
                if (!outstanding) r.state <= ST_IDLE;
            end
`endif
        end else begin
            if (!stall) r.f.valid <= 1'b0;
            if (!stall && r.skid_valid) begin
                r.f          <= r.skid;
                r.skid_valid <= 1'b0;
            end
            if (r.state == ST_RESET) r.state <= ST_REQ;
            if (r.state == ST_DRAIN && imem_ready) begin
                r.state <= r.halt ? ST_IDLE : ST_REQ;
                r.addr  <= {r.pc[31:2], 2'b00};
            end
            if (r.state == ST_IDLE && !r.halt && !r.skid_valid && !buf16) begin
                r.state <= ST_REQ;
                r.addr  <= idle_addr;
            end
            if (fault || (apply && issue)) begin
                if (stall) begin
                    r.skid       <= pkt;
                    r.skid_valid <= 1'b1;
                end else begin
                    r.f <= pkt;
                end
            end
            if (fault) begin
                r.halt  <= 1'b1;
                r.state <= ST_IDLE;
            end
            if (apply) begin
                r.pc    <= next_pc;
                r.state <= ((issue && stall) || nxt_idle) ? ST_IDLE : ST_REQ;
                r.addr  <= nxt_addr;
`ifdef COMPRESSED_EN
                hb_valid <= hb_set;
                hb_data  <= imem_rdata[31:16];
                hb_addr  <= next_pc;
`endif
            end
        end
    end

    assign imem_valid  = r.state == ST_REQ || r.state == ST_DRAIN;
    assign imem_addr   = r.addr;
    assign imem_instr  = 1'b1;
    assign imem_wstrb  = 4'b0000;
    assign f_valid     = r.f.valid;
    assign f_pc        = r.f.pc;
    assign f_instr     = r.f.instr;
    assign f_exception = r.f.exception;
    assign f_ecause    = r.f.ecause;
    assign f_etval     = r.f.etval;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage against hand-computed expectations.
module tb_fetch_stage;
    logic        clk = 1'b0, rst = 1'b1;
    logic        imem_valid, imem_instr;
    logic [3:0]  imem_wstrb;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0, imem_err = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        stall = 1'b0, redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        f_valid, f_exception;
    logic [31:0] f_pc, f_instr, f_etval;
    logic [3:0]  f_ecause;
    int errors = 0, checks = 0;

    fetch_stage dut (
        .clk(clk), .rst(rst),
        .imem_valid(imem_valid), .imem_instr(imem_instr), .imem_wstrb(imem_wstrb), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .imem_err(imem_err),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .f_valid(f_valid), .f_pc(f_pc), .f_instr(f_instr),
        .f_exception(f_exception), .f_ecause(f_ecause), .f_etval(f_etval)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic respond(input logic [31:0] data, input logic err);
        check("req_valid", 32'(imem_valid), 1);
        imem_ready = 1'b1;
        imem_rdata = data;
        imem_err   = err;
        step;
        imem_ready = 1'b0;
        imem_err   = 1'b0;
    endtask

    task automatic jump(input logic [31:0] target);
        redirect    = 1'b1;
        redirect_pc = target;
        step;
        redirect    = 1'b0;
    endtask

    initial begin
        repeat (3) step;
        check("rst_fvalid", 32'(f_valid), 0);
        check("rst_fpc", f_pc, 32'h80000000);
        check("rst_finstr", f_instr, 0);
        check("rst_fexc", 32'(f_exception), 0);
        check("rst_fecause", 32'(f_ecause), 0);
        check("rst_fetval", f_etval, 0);
        check("rst_imem_valid", 32'(imem_valid), 0);

        rst = 1'b0;
        step;
        check("first_addr", imem_addr, 32'h80000000);
        check("imem_instr", 32'(imem_instr), 1);
        check("imem_wstrb", 32'(imem_wstrb), 0);
        respond(32'h00000013, 1'b0);
        check("first_fvalid", 32'(f_valid), 1);
        check("first_fpc", f_pc, 32'h80000000);
        check("first_finstr", f_instr, 32'h00000013);
        check("next_addr", imem_addr, 32'h80000004);
        step;
        check("bubble_fvalid", 32'(f_valid), 0);
        check("held_addr", imem_addr, 32'h80000004);

        respond(32'h00200113, 1'b0);
        check("a_fpc", f_pc, 32'h80000004);
        stall = 1'b1;
        respond(32'h00300193, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("stall_fvalid", 32'(f_valid), 1);
            check("stall_fpc", f_pc, 32'h80000004);
            check("stall_finstr", f_instr, 32'h00200113);
            check("stall_no_req", 32'(imem_valid), 0);
            if (i < 2) step;
        end
        stall = 1'b0;
        step;
        check("skid_fvalid", 32'(f_valid), 1);
        check("skid_fpc", f_pc, 32'h80000008);
        check("skid_finstr", f_instr, 32'h00300193);
        step;
        check("after_skid_addr", imem_addr, 32'h8000000C);
        check("after_skid_fvalid", 32'(f_valid), 0);

        respond(32'h00000013, 1'b0);
        check("pre_err_addr", imem_addr, 32'h80000010);
        respond(32'hDEADBEEF, 1'b1);
        check("err_fvalid", 32'(f_valid), 1);
        check("err_fexc", 32'(f_exception), 1);
        check("err_fecause", 32'(f_ecause), 1);
        check("err_fetval", f_etval, 32'h80000010);
        check("err_fpc", f_pc, 32'h80000010);
        check("err_finstr", f_instr, 0);
        for (int i = 0; i < 3; i++) begin
            check("err_no_req", 32'(imem_valid), 0);
            step;
        end

        jump(32'h80000100);
        check("redir_fvalid", 32'(f_valid), 0);
        check("redir_fexc", 32'(f_exception), 0);
        check("redir_addr", imem_addr, 32'h80000100);
        jump(32'h80000200);
        check("drain_addr_held", imem_addr, 32'h80000100);
        check("drain_valid", 32'(imem_valid), 1);
        step;
        respond(32'hDEADBEEF, 1'b0);
        check("drain_discard", 32'(f_valid), 0);
        check("drain_new_addr", imem_addr, 32'h80000200);
        respond(32'h00000513, 1'b0);
        check("target_fpc", f_pc, 32'h80000200);
        check("target_finstr", f_instr, 32'h00000513);

        jump(32'hFFFFFFFC);
        respond(32'hDEADBEEF, 1'b0);
        check("wrap_req", imem_addr, 32'hFFFFFFFC);
        respond(32'h00000013, 1'b0);
        check("wrap_fpc", f_pc, 32'hFFFFFFFC);
        check("wrap_addr", imem_addr, 32'h00000000);

        rst = 1'b1;
        step;
        check("mid_rst_valid", 32'(imem_valid), 0);
        check("mid_rst_fpc", f_pc, 32'h80000000);
        rst = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        step;
        imem_ready = 1'b0;
        check("stale_ignored", 32'(f_valid), 0);
        check("restart_addr", imem_addr, 32'h80000000);
        check("restart_valid", 32'(imem_valid), 1);

`ifdef COMPRESSED_EN
        respond(32'h00014501, 1'b0);
        check("c16_finstr", f_instr, 32'h00004501);
        check("c16_fpc", f_pc, 32'h80000000);
        check("c16_no_req", 32'(imem_valid), 0);
        step;
        check("cbuf_finstr", f_instr, 32'h00000001);
        check("cbuf_fpc", f_pc, 32'h80000002);
        check("cbuf_addr", imem_addr, 32'h80000004);
        jump(32'h80000102);
        respond(32'hDEADBEEF, 1'b0);
        check("split_addr0", imem_addr, 32'h80000100);
        respond(32'h45031111, 1'b0);
        check("split_wait", 32'(f_valid), 0);
        check("split_addr1", imem_addr, 32'h80000104);
        respond(32'h22220000, 1'b0);
        check("split_finstr", f_instr, 32'h00004503);
        check("split_fpc", f_pc, 32'h80000102);
        check("split_no_req", 32'(imem_valid), 0);
        step;
        check("tail_finstr", f_instr, 32'h00002222);
        check("tail_fpc", f_pc, 32'h80000106);
`else
        jump(32'h80000302);
        check("mis_bubble", 32'(f_valid), 0);
        step;
        check("mis_fvalid", 32'(f_valid), 1);
        check("mis_fexc", 32'(f_exception), 1);
        check("mis_fecause", 32'(f_ecause), 0);
        check("mis_fetval", f_etval, 32'h80000302);
        check("mis_drain_addr", imem_addr, 32'h80000000);
        respond(32'hDEADBEEF, 1'b0);
        check("mis_no_req", 32'(imem_valid), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
